// File: rtl/sram_like_slave.sv
// sram_like_slave: SRAM-like bus responder with an internal word memory and in-order,
// fixed-latency data_ok returns; optional LFSR stalls on addr_ok/data_ok.
module sram_like_slave #(
    parameter int MEM_AW  = 12,
    parameter int QDEPTH  = 4,
    parameter int LAT     = 2,
    parameter bit RAND_EN = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(QDEPTH);
    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

    logic [31:0]       mem_q [2**MEM_AW];
    logic [31:0]       snap_q [QDEPTH];
    logic [3:0]        cnt_q [QDEPTH];
    logic [PW-1:0]     wp_q, rp_q;
    logic [CW-1:0]     count_q, count_d;
    logic [7:0]        lfsr_q, lfsr_d;
    logic [MEM_AW-1:0] widx;
    logic              push, pop;
    logic              unused_bits;

    // Transfer size never matters: lanes come straight from wstrb and reads return whole words.
    assign unused_bits = ^{size, addr[31:MEM_AW+2], addr[1:0]};
    assign widx    = addr[MEM_AW+1:2];
    assign addr_ok = req & ~reset & (count_q < FULL) & (~RAND_EN | lfsr_q[0]);
    assign data_ok = ~reset & (count_q != '0) & (cnt_q[rp_q] == '0) & (~RAND_EN | lfsr_q[1]);
    assign rdata   = data_ok ? snap_q[rp_q] : '0;
    assign push    = addr_ok;
    assign pop     = data_ok;
    assign count_d = count_q + CW'(push) - CW'(pop);
    assign lfsr_d  = RAND_EN ? {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]} : lfsr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            lfsr_q  <= 8'hA5;
            for (int k = 0; k < QDEPTH; k++) cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < QDEPTH; k++) cnt_q[k] <= (cnt_q[k] == '0) ? '0 : cnt_q[k] - 4'd1;
            if (push) cnt_q[wp_q] <= LAT_M1;
            wp_q    <= push ? wp_q + 1'b1 : wp_q;
            rp_q    <= pop ? rp_q + 1'b1 : rp_q;
            count_q <= count_d;
            lfsr_q  <= lfsr_d;
        end
    end

    // Read snapshot sees every write from earlier cycles; write entries return zero.
    always_ff @(posedge clk) begin
        if (push) snap_q[wp_q] <= wr ? '0 : mem_q[widx];
        if (push && wr)
            for (int i = 0; i < 4; i++)
                if (wstrb[i]) mem_q[widx][8*i +: 8] <= wdata[8*i +: 8];
    end
endmodule

// File: tb/tb_sram_like_slave.sv
// tb_sram_like_slave: three responder configurations driven by directed and random
// traffic, checked every cycle against a queue/timestamp reference model.
module tb_sram_like_slave;
    localparam int NI = 3;
    localparam int QD = 4;
    localparam int LATV [NI] = '{2, 8, 3};
    localparam bit RANDV [NI] = '{1'b0, 1'b0, 1'b1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [NI];
    logic        req [NI];
    logic        wr [NI];
    logic [1:0]  size [NI];
    logic [31:0] addr [NI];
    logic [3:0]  wstrb [NI];
    logic [31:0] wdata [NI];
    logic        addr_ok [NI];
    logic        data_ok [NI];
    logic [31:0] rdata [NI];

    sram_like_slave #(.MEM_AW(12), .QDEPTH(QD), .LAT(2), .RAND_EN(1'b0)) u0 (
        .clk(clk), .reset(rst[0]), .req(req[0]), .wr(wr[0]), .size(size[0]), .addr(addr[0]),
        .wstrb(wstrb[0]), .wdata(wdata[0]), .addr_ok(addr_ok[0]), .data_ok(data_ok[0]), .rdata(rdata[0]));
    sram_like_slave #(.MEM_AW(12), .QDEPTH(QD), .LAT(8), .RAND_EN(1'b0)) u1 (
        .clk(clk), .reset(rst[1]), .req(req[1]), .wr(wr[1]), .size(size[1]), .addr(addr[1]),
        .wstrb(wstrb[1]), .wdata(wdata[1]), .addr_ok(addr_ok[1]), .data_ok(data_ok[1]), .rdata(rdata[1]));
    sram_like_slave #(.MEM_AW(12), .QDEPTH(QD), .LAT(3), .RAND_EN(1'b1)) u2 (
        .clk(clk), .reset(rst[2]), .req(req[2]), .wr(wr[2]), .size(size[2]), .addr(addr[2]),
        .wstrb(wstrb[2]), .wdata(wdata[2]), .addr_ok(addr_ok[2]), .data_ok(data_ok[2]), .rdata(rdata[2]));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_acc2 = 0;
    int n_dok2 = 0;

    // Reference: outstanding returns as (data, due cycle) queues plus a plain word array.
    logic [31:0] mm [NI][4096];
    logic [31:0] qd [NI][$];
    int          qt [NI][$];
    logic [7:0]  lf [NI];
    int          dc [NI][$];
    logic [31:0] dd [NI][$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic bit m_aok(int i);
        return req[i] && !rst[i] && qd[i].size() < QD && (!RANDV[i] || lf[i][0]);
    endfunction

    function automatic bit m_dok(int i);
        return !rst[i] && qd[i].size() > 0 && cyc >= qt[i][0] && (!RANDV[i] || lf[i][1]);
    endfunction

    function automatic int lc(int i, int k);
        return k < dc[i].size() ? dc[i][k] : -1;
    endfunction

    function automatic logic [31:0] ld(int i, int k);
        return k < dd[i].size() ? dd[i][k] : 32'hDEAD_BEEF;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            bit a, d;
            int ix;
            a = m_aok(i);
            d = m_dok(i);
            ix = int'(addr[i][13:2]);
            if (rst[i]) begin
                qd[i].delete();
                qt[i].delete();
                lf[i] = 8'hA5;
            end else begin
                if (d) begin
                    void'(qd[i].pop_front());
                    void'(qt[i].pop_front());
                end
                if (a) begin
                    qd[i].push_back(wr[i] ? 32'h0 : mm[i][ix]);
                    qt[i].push_back(cyc + LATV[i]);
                    if (wr[i])
                        for (int b = 0; b < 4; b++)
                            if (wstrb[i][b]) mm[i][ix][8*b +: 8] = wdata[i][8*b +: 8];
                end
                if (RANDV[i]) lf[i] = {lf[i][6:0], lf[i][7] ^ lf[i][5] ^ lf[i][4] ^ lf[i][3]};
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            bit ea, ed;
            logic [31:0] er;
            ea = m_aok(i);
            ed = m_dok(i);
            er = ed ? qd[i][0] : 32'h0;
            chk($sformatf("addr_ok[%0d]@%0d", i, cyc), {31'b0, addr_ok[i]}, {31'b0, ea});
            chk($sformatf("data_ok[%0d]@%0d", i, cyc), {31'b0, data_ok[i]}, {31'b0, ed});
            chk($sformatf("rdata[%0d]@%0d", i, cyc), rdata[i], er);
            if (data_ok[i]) begin
                dc[i].push_back(cyc);
                dd[i].push_back(rdata[i]);
            end
        end
        n_acc2 += int'(addr_ok[2]);
        n_dok2 += int'(data_ok[2]);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic xfer(input int i, input bit w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, output int t);
        req[i] = 1'b1;
        wr[i] = w;
        addr[i] = a;
        wstrb[i] = s;
        wdata[i] = d;
        size[i] = 2'($urandom_range(0, 3));
        t = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (addr_ok[i]) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) begin
            n_bad++;
            $display("FAIL accept_timeout[%0d]: no addr_ok within 200 cycles", i);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t0, t1, t5, g;
        int ta [4];
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0, t1, t5, g;
        int ta [4];
        for (int i = 0; i < NI; i++) begin
            rst[i] = 1'b1;
            req[i] = 1'b1;
            wr[i] = 1'b0;
            size[i] = 2'd2;
            addr[i] = 32'h0;
            wstrb[i] = 4'h0;
            wdata[i] = 32'h0;
            lf[i] = 8'hA5;
        end
        step(3);
        for (int i = 0; i < NI; i++) begin
            rst[i] = 1'b0;
            req[i] = 1'b0;
        end
        @(negedge clk);
        chk("addr_ok_after_reset", {31'b0, addr_ok[0]}, 32'h0);
        step(1);

        // write then read, LAT=2
        dc[0].delete(); dd[0].delete();
        xfer(0, 1'b1, 32'h1c00_0000, 4'hF, 32'h1234_5678, t0);
        xfer(0, 1'b0, 32'h1c00_0000, 4'h0, 32'h0, t1);
        req[0] = 1'b0;
        step(5);
        chk("wr_rd_accept_gap", t1, t0 + 1);
        chk("wr_dok_cycle", lc(0, 0), t0 + 2);
        chk("wr_dok_rdata", ld(0, 0), 32'h0);
        chk("rd_dok_cycle", lc(0, 1), t0 + 3);
        chk("rd_dok_rdata", ld(0, 1), 32'h1234_5678);

        // partial write lane 2
        dc[0].delete(); dd[0].delete();
        xfer(0, 1'b1, 32'h1c00_0000, 4'b0100, 32'h00AB_0000, t0);
        xfer(0, 1'b0, 32'h1c00_0000, 4'h0, 32'h0, t1);
        req[0] = 1'b0;
        step(5);
        chk("partial_rdata", ld(0, 1), 32'h12AB_5678);

        // address wrap modulo 4096 words
        dc[0].delete(); dd[0].delete();
        xfer(0, 1'b1, 32'h0000_0010, 4'hF, 32'hCAFE_F00D, t0);
        xfer(0, 1'b0, 32'h0000_4010, 4'h0, 32'h0, t1);
        req[0] = 1'b0;
        step(5);
        chk("wrap_rdata", ld(0, 1), 32'hCAFE_F00D);

        // pipelined reads
        for (int k = 0; k < 4; k++) xfer(0, 1'b1, 32'h100 + 32'(4 * k), 4'hF, 32'hA000_0000 + 32'(k * 17), t0);
        req[0] = 1'b0;
        step(5);
        dc[0].delete(); dd[0].delete();
        for (int k = 0; k < 4; k++) xfer(0, 1'b0, 32'h100 + 32'(4 * k), 4'h0, 32'h0, ta[k]);
        req[0] = 1'b0;
        step(6);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("pipe_accept%0d", k), ta[k], ta[0] + k);
            chk($sformatf("pipe_dok%0d", k), lc(0, k), ta[0] + 2 + k);
            chk($sformatf("pipe_rdata%0d", k), ld(0, k), 32'hA000_0000 + 32'(k * 17));
        end

        // full queue, LAT=8
        for (int k = 0; k < 4; k++) xfer(1, 1'b1, 32'h200 + 32'(4 * k), 4'hF, 32'hB000_0000 + 32'(k), t0);
        req[1] = 1'b0;
        step(14);
        dc[1].delete(); dd[1].delete();
        for (int k = 0; k < 4; k++) xfer(1, 1'b0, 32'h200 + 32'(4 * k), 4'h0, 32'h0, ta[k]);
        xfer(1, 1'b0, 32'h200, 4'h0, 32'h0, t5);
        req[1] = 1'b0;
        step(14);
        for (int k = 0; k < 4; k++) chk($sformatf("full_accept%0d", k), ta[k], ta[0] + k);
        chk("full_next_accept", t5, ta[0] + 9);
        chk("full_first_dok", lc(1, 0), ta[0] + 8);
        chk("full_first_rdata", ld(1, 0), 32'hB000_0000);

        // reset with two reads in flight
        dc[1].delete(); dd[1].delete();
        xfer(1, 1'b0, 32'h204, 4'h0, 32'h0, t0);
        xfer(1, 1'b0, 32'h208, 4'h0, 32'h0, t1);
        req[1] = 1'b0;
        step(1);
        rst[1] = 1'b1;
        step(1);
        rst[1] = 1'b0;
        step(10);
        chk("flush_no_dok", dc[1].size(), 0);
        xfer(1, 1'b0, 32'h20C, 4'h0, 32'h0, t0);
        req[1] = 1'b0;
        step(10);
        chk("post_reset_dok", lc(1, 0), t0 + 8);
        chk("post_reset_rdata", ld(1, 0), 32'hB000_0003);

        // random stalls and mixed traffic
        for (int k = 0; k < 16; k++) xfer(2, 1'b1, 32'h300 + 32'(4 * k), 4'hF, $urandom, t0);
        req[2] = 1'b0;
        step(40);
        n_acc2 = 0;
        n_dok2 = 0;
        for (int n = 0; n < 200; n++) begin
            g = $urandom_range(0, 2);
            if (g > 0) begin
                req[2] = 1'b0;
                addr[2] = $urandom;
                step(g);
            end
            t1 = $urandom_range(0, 15);
            xfer(2, 1'($urandom_range(0, 1)), ($urandom & 32'hFFFF_C003) | (32'h300 + 32'(4 * t1)),
                 4'($urandom), $urandom, t0);
        end
        req[2] = 1'b0;
        step(60);
        chk("rand_accepts", n_acc2, 200);
        chk("rand_returns", n_dok2, 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
